mdu_iterative: RTL and testbench

//  Parametrised multiply/divide unit for the EX stage. Holds architectural HI/LO

---
 rtl/mdu_iterative.sv | 255 +++++++++++++++++++++++++
 tb/tb_mdu_iterative.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// mdu_iterative: multiply/divide unit with architectural HI/LO registers.
// Runs MULT/MULTU/DIV/DIVU iteratively (radix-2 shift-add multiply and
// restoring divide) under a start/busy/done handshake. MTHI/MTLO write
// HI/LO directly without going busy.
// Optional feature: define MDU_MACC_EN to add MADD/MADDU/MSUB/MSUBU
// (ops 6-9), which accumulate the product into {HI,LO}.
module mdu_iterative #(
    parameter int WIDTH    = 32,
    parameter int MUL_FAST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div0,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MACC_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_ma;
    logic [WIDTH-1:0]     r_mb;
    logic                 r_sa;
    logic                 r_sb;
    logic                 r_isDiv;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_div0;
`ifdef MDU_MACC_EN
    logic                 r_macc;
    logic                 r_sub;
`endif

    // Operation decode of the incoming request
    logic                 w_opMul;
    logic                 w_opDiv;
    logic                 w_opSigned;
    logic                 w_opArith;
    logic                 w_signA;
    logic                 w_signB;
    logic [WIDTH-1:0]     w_magA;
    logic [WIDTH-1:0]     w_magB;

`ifdef MDU_MACC_EN
    logic                 w_opMacc;
    logic                 w_opSub;
    assign w_opMacc   = (i_op == OP_MADD) || (i_op == OP_MADDU) ||
                        (i_op == OP_MSUB) || (i_op == OP_MSUBU);
    assign w_opSub    = (i_op == OP_MSUB) || (i_op == OP_MSUBU);
    assign w_opMul    = (i_op == OP_MULT) || (i_op == OP_MULTU) || w_opMacc;
    assign w_opSigned = (i_op == OP_MULT) || (i_op == OP_DIV) ||
                        (i_op == OP_MADD) || (i_op == OP_MSUB);
`else
    assign w_opMul    = (i_op == OP_MULT) || (i_op == OP_MULTU);
    assign w_opSigned = (i_op == OP_MULT) || (i_op == OP_DIV);
`endif
    assign w_opDiv    = (i_op == OP_DIV) || (i_op == OP_DIVU);
    assign w_opArith  = w_opMul || w_opDiv;

    assign w_signA = w_opSigned & i_a[WIDTH-1];
    assign w_signB = w_opSigned & i_b[WIDTH-1];
    assign w_magA  = w_signA ? -i_a : i_a;
    assign w_magB  = w_signB ? -i_b : i_b;

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit (LSB) is set, then shift the whole pair right.
    logic [WIDTH:0]       w_mulSum;
    logic [2*WIDTH-1:0]   w_mulNext;
    assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_ma : {WIDTH{1'b0}})};
    assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

    // One restoring-divide step: shift the next dividend bit into the partial
    // remainder and subtract the divisor whenever it fits.
    logic [WIDTH:0]       w_remShift;
    logic                 w_qBit;
    logic [WIDTH-1:0]     w_remNext;
    logic [2*WIDTH-1:0]   w_divNext;
    assign w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_qBit     = (w_remShift >= {1'b0, r_mb});
    assign w_remNext  = w_qBit ? (w_remShift[WIDTH-1:0] - r_mb) : w_remShift[WIDTH-1:0];
    assign w_divNext  = {w_remNext, r_acc[WIDTH-2:0], w_qBit};

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_aRaw;
    assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quot = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_aRaw = r_sa ? -r_ma : r_ma;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: fast multiplies skip straight to FIX
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start && w_opArith) begin
                    if ((MUL_FAST != 0) && !w_opDiv) begin
                        w_nextState = S_FIX;
                    end else begin
                        w_nextState = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_nextState = S_FIX;
                end
            end
            S_FIX: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Outputs: busy is high whenever an arithmetic op is in flight
    always_comb begin
        o_busy = (r_state != S_IDLE);
    end

    assign o_done = r_done;
    assign o_div0 = r_div0;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

    // Datapath: operand capture, iteration, and final HI/LO write-back
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_isDiv <= 1'b0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
`ifdef MDU_MACC_EN
            r_macc  <= 1'b0;
            r_sub   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_op == OP_MTHI) begin
                            r_hi   <= i_a;
                            r_div0 <= 1'b0;
                        end else if (i_op == OP_MTLO) begin
                            r_lo   <= i_a;
                            r_div0 <= 1'b0;
                        end else if (w_opArith) begin
                            r_div0  <= 1'b0;
                            r_ma    <= w_magA;
                            r_mb    <= w_magB;
                            r_sa    <= w_signA;
                            r_sb    <= w_signB;
                            r_isDiv <= w_opDiv;
                            r_cnt   <= CW'(WIDTH - 1);
`ifdef MDU_MACC_EN
                            r_macc  <= w_opMacc;
                            r_sub   <= w_opSub;
`endif
                            if (w_opDiv) begin
                                r_acc <= {{WIDTH{1'b0}}, w_magA};
                            end else if (MUL_FAST != 0) begin
                                r_acc <= {{WIDTH{1'b0}}, w_magA} * {{WIDTH{1'b0}}, w_magB};
                            end else begin
                                r_acc <= {{WIDTH{1'b0}}, w_magB};
                            end
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= r_isDiv ? w_divNext : w_mulNext;
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_isDiv) begin
                        if (r_mb == '0) begin
                            r_lo   <= '1;
                            r_hi   <= w_aRaw;
                            r_div0 <= 1'b1;
                        end else begin
                            r_lo <= w_quot;
                            r_hi <= w_rem;
                        end
                    end else begin
`ifdef MDU_MACC_EN
                        if (r_macc && r_sub) begin
                            {r_hi, r_lo} <= {r_hi, r_lo} - w_prod;
                        end else if (r_macc) begin
                            {r_hi, r_lo} <= {r_hi, r_lo} + w_prod;
                        end else begin
                            {r_hi, r_lo} <= w_prod;
                        end
`else
                        {r_hi, r_lo} <= w_prod;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: self-checking bench for mdu_iterative (WIDTH=32, MUL_FAST=0).
// Directed vector table, randomized ops against an arithmetic reference
// model, and hand-written sequences for reset abort, start-while-busy,
// undefined ops, MTHI/MTLO and (with MDU_MACC_EN) multiply-accumulate.
module tb_mdu_iterative;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    op = 4'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic          div0;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int vectors = 0;
    int miscompares = 0;

    mdu_iterative #(
        .WIDTH(W),
        .MUL_FAST(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_start(start),
        .i_op(op),
        .i_a(a),
        .i_b(b),
        .o_busy(busy),
        .o_done(done),
        .o_div0(div0),
        .o_hi(hi),
        .o_lo(lo)
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        logic        expDiv0;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the operands
    function automatic logic [63:0] modelMul(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint p;
        if (o == 4'd0 || o == 4'd6 || o == 4'd8) begin
            p = longint'($signed(x)) * longint'($signed(y));
            return p;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    // Returns {hi, lo}
    function automatic logic [63:0] modelDiv(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (o == 4'd2) begin
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, x};
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
        end
        return {x % y, x / y};
    endfunction

    // Wait for done with a bounded budget, counting busy cycles seen
    task automatic waitDone(output int busyCycles, output bit gotDone);
        busyCycles = 0;
        gotDone = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                gotDone = 1'b1;
                break;
            end
            if (busy) busyCycles++;
            step();
        end
    endtask

    // Issue one op; operands are scrambled right after the accepting edge
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output int busyCycles, output bit gotDone);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        step();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        waitDone(busyCycles, gotDone);
    endtask

    task automatic runArith(input string name, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] expHi, input logic [31:0] expLo, input logic expDiv0);
        int  bc;
        bit  gd;
        applyStimulus(o, x, y, bc, gd);
        checkOutput({name, " done"}, 64'(gd), 64'd1);
        checkOutput({name, " busyCycles"}, 64'(bc), 64'(W + 1));
        checkOutput({name, " busy@done"}, 64'(busy), 64'd0);
        checkOutput({name, " hi"}, 64'(hi), 64'(expHi));
        checkOutput({name, " lo"}, 64'(lo), 64'(expLo));
        checkOutput({name, " div0"}, 64'(div0), 64'(expDiv0));
    endtask

    task automatic applyMt(input logic [3:0] o, input logic [31:0] x);
        start = 1'b1;
        op = o;
        a = x;
        step();
        start = 1'b0;
        a = $urandom;
        checkOutput("mt busy", 64'(busy), 64'd0);
        checkOutput("mt done", 64'(done), 64'd0);
    endtask

    vec_t table_v[10];

    initial begin
        logic [63:0] expHL;
        logic [31:0] rx;
        logic [31:0] ry;
        logic [3:0]  ro;
        logic [31:0] saveHi;
        logic [31:0] saveLo;
        int          bc;
        bit          gd;

        table_v[0] = '{"MULT -3*7",     4'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        table_v[1] = '{"DIVU 100/7",    4'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        table_v[2] = '{"DIV -7/2",      4'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        table_v[3] = '{"DIV 5/0",       4'd2, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        table_v[4] = '{"DIV ovf",       4'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        table_v[5] = '{"MULTU max",     4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        table_v[6] = '{"DIVU x/0",      4'd3, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        table_v[7] = '{"DIV -7/0",      4'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        table_v[8] = '{"MULT min*min",  4'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        table_v[9] = '{"DIV 7/-2",      4'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};

        // Reset state
        repeat (3) step();
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset div0", 64'(div0), 64'd0);
        reset = 1'b1;
        step();

        // Directed table; consecutive ops start in the done cycle of the previous one
        for (int i = 0; i < 10; i++) begin
            runArith(table_v[i].name, table_v[i].op, table_v[i].a, table_v[i].b,
                     table_v[i].expHi, table_v[i].expLo, table_v[i].expDiv0);
        end

        // done is a single-cycle pulse
        step();
        checkOutput("done pulse width", 64'(done), 64'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 3));
            rx = $urandom;
            case ($urandom_range(0, 5))
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(1, 20));
                2: ry = 32'hFFFFFFFF;
                default: ry = $urandom;
            endcase
            if (ro < 4'd2) expHL = modelMul(ro, rx, ry);
            else           expHL = modelDiv(ro, rx, ry);
            runArith("rand", ro, rx, ry, expHL[63:32], expHL[31:0], (ro >= 4'd2) && (ry == 32'd0));
        end

        // MTHI / MTLO
        applyMt(4'd4, 32'h12345678);
        checkOutput("MTHI hi", 64'(hi), 64'h12345678);
        applyMt(4'd5, 32'h9ABCDEF0);
        checkOutput("MTLO lo", 64'(lo), 64'h9ABCDEF0);
        checkOutput("MTLO hi kept", 64'(hi), 64'h12345678);

        // Undefined ops are ignored
        start = 1'b1;
        op = 4'd13;
        a = 32'hDEADBEEF;
        b = 32'd3;
        step();
        start = 1'b0;
        checkOutput("undef op busy", 64'(busy), 64'd0);
`ifndef MDU_MACC_EN
        start = 1'b1;
        op = 4'd6;
        step();
        start = 1'b0;
        checkOutput("op6 disabled busy", 64'(busy), 64'd0);
`endif
        step();
        checkOutput("undef op hi", 64'(hi), 64'h12345678);
        checkOutput("undef op lo", 64'(lo), 64'h9ABCDEF0);

        // Start while busy: DIVU is ignored, MULT completes unchanged
        start = 1'b1;
        op = 4'd0;
        a = 32'hFFFFFFFD;
        b = 32'd7;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1;
        op = 4'd3;
        a = 32'd100;
        b = 32'd7;
        step();
        start = 1'b0;
        waitDone(bc, gd);
        checkOutput("busy-start done", 64'(gd), 64'd1);
        checkOutput("busy-start remaining busy", 64'(bc), 64'(W + 1 - 5));
        checkOutput("busy-start hi", 64'(hi), 64'hFFFFFFFF);
        checkOutput("busy-start lo", 64'(lo), 64'hFFFFFFEB);
        step();
        checkOutput("busy-start no queue", 64'(busy), 64'd0);

        // Reset aborts an in-flight MULTU without writing HI/LO
        applyMt(4'd4, 32'hCAFEF00D);
        saveHi = hi;
        saveLo = lo;
        checkOutput("pre-abort hi", 64'(saveHi), 64'hCAFEF00D);
        start = 1'b1;
        op = 4'd1;
        a = 32'd1234;
        b = 32'd5678;
        step();
        start = 1'b0;
        repeat (9) step();
        reset = 1'b0;
        step();
        checkOutput("abort hi", 64'(hi), 64'd0);
        checkOutput("abort lo", 64'(lo), 64'd0);
        checkOutput("abort busy", 64'(busy), 64'd0);
        reset = 1'b1;
        repeat (40) begin
            step();
            if (done) break;
        end
        checkOutput("abort no late done", 64'(done), 64'd0);
        checkOutput("abort lo stays", 64'(lo), 64'd0);

`ifdef MDU_MACC_EN
        // Multiply-accumulate
        applyMt(4'd4, 32'd0);
        applyMt(4'd5, 32'd10);
        runArith("MADD 2*3", 4'd6, 32'd2, 32'd3, 32'd0, 32'd16, 1'b0);
        runArith("MSUBU 20*1", 4'd9, 32'd20, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFC, 1'b0);
        runArith("MSUB -1*-1", 4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
